seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised, runtime-programmable serial bit-pattern detector. It replaces the fixed-pattern Moore detectors in the FSM section. A pattern of 1..MAX_LEN bits is matched against a gated serial stream, in overlapping or non-overlapping mode. Each detection gives a registered one-cycle `dout` pulse and increments a saturating match counter. It sits between a serial bit source and downstream event logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of `match_cnt`.
- `PATTERN_RST`, 8'b0001_0010: pattern register value after reset (LSB-aligned).
- `LEN_RST`, 5: pattern length after reset.
- `OVERLAP_RST`, 1'b1: overlap mode after reset.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `en`  in  1  bit-valid; `din` consumed only on edges where `en`=1.
- `din`  in  1  serial data bit.
- `cfg_load`  in  1  load `cfg_pattern`/`cfg_len`/`cfg_overlap` this edge.
- `cfg_pattern`  in  MAX_LEN  pattern; bit [len-1] is matched first, bit [0] last.
- `cfg_len`  in  $clog2(MAX_LEN)+1  pattern length; valid range 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `dout`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `armed`  out  1  high in RUN (history holds ≥ len valid bits).
- `cfg_err`  out  1  sticky; last `cfg_load` had an invalid length.

## Operation
- **Registers:**
  - pattern `pat`, length `len`, overlap `ovl`.
  - history shift register `hist[MAX_LEN-1:0]`; new bit enters at [0].
  - fill counter `fill`, 0..len.
  - state ∈ {IDLE, FILL, RUN}.
- **Reset values:**
  - `pat`=PATTERN_RST, `len`=LEN_RST, `ovl`=OVERLAP_RST.
  - `hist`=0, `fill`=0, state=IDLE.
  - `dout`=0, `match_cnt`=0, `armed`=0, `cfg_err`=0.
- **State transitions:**
  - IDLE → FILL unconditionally on the next edge if `len` is valid. Stays in IDLE if `len` is invalid; `en` ignored.
  - FILL: each accepted bit shifts `hist` and increments `fill`. When the accepted bit makes `fill`=len, go to RUN and evaluate a match on that same edge.
  - RUN: each accepted bit shifts `hist`, then evaluates a match.
- **Match condition:** `{hist,din}` low `len` bits == `pat[len-1:0]`, evaluated using the post-shift history.
- **On a match:**
  - `dout`←1 for exactly one cycle.
  - `match_cnt` increments, saturating at 2^CNT_W−1.
  - If `ovl`=1: stay in RUN with history kept.
  - If `ovl`=0: clear `hist` and `fill`, go to FILL. The next match needs `len` fresh bits.
- **`en`=0 edge:** history, `fill` and state hold; `dout`←0.
- **`cfg_load`=1 edge (any state; wins over `en`):**
  - Latch pattern, length and overlap; clear `hist` and `fill`; `dout`←0; the `din` bit on that edge is discarded.
  - Valid length: go to FILL and clear `cfg_err`.
  - Invalid length (0 or >MAX_LEN): go to IDLE, set `cfg_err`, and load `len` anyway. The block stays in IDLE until a valid `cfg_load`.
- **`cnt_clr`:** sets `match_cnt`←0. On the same edge as a match, clear wins (result 0); `dout` still pulses.
- **`armed`:** `armed` = (state==RUN).
- **Length 1:** every accepted bit equal to `pat[0]` produces a match, including back-to-back matches.

## Timing
- All outputs are registered; no combinational path from input to output.
- Match latency: final pattern bit sampled at edge k → `dout`=1 from edge k to edge k+1.
- Overlap mode: back-to-back `dout` pulses are possible on consecutive accepted bits.
- After reset release: IDLE for 1 edge, then FILL. The first match is possible on the `len`-th accepted bit.
- `cfg_load` takes effect at its edge. The first accepted bit is the one on the following edge.
- `rst` asserted at any time (mid-FILL, mid-RUN, or during a `dout` pulse) forces all reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset defaults, overlap:** release `rst`, `en`=1, stream 1,0,0,1,0,0,1,0 → `dout` pulses after bit 5 and bit 8; `match_cnt`=2; `armed` rises on bit 5.
- **Non-overlap:** `cfg_load` with pattern 5'b10010, `cfg_len`=5, `cfg_overlap`=0, then the same stream → single pulse after bit 5; `match_cnt`=1.
- **Gating:** insert `en`=0 gaps between bits of 1,0,0,1,0 → one pulse, one cycle after the 5th accepted bit; no pulse in gap cycles.
- **Config error:** `cfg_load` with `cfg_len`=0 → `cfg_err`=1, state IDLE, no matches for any stream. Then load `cfg_len`=3, pattern 3'b101, stream 1,0,1,0,1 → `cfg_err`=0 and pulses after bits 3 and 5.
- **Counter:** `CNT_W`=2, length-1 pattern `1`, stream of 5 ones → `match_cnt` saturates at 3. `cnt_clr` on the same edge as a match → `match_cnt`=0 and `dout`=1.
- **Async reset:** assert `rst` between clock edges after 4 bits of 10010 → `dout`, `match_cnt`, `armed` go to 0 before the next edge. After release, state is IDLE and the full 5 bits are needed to match.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-pattern detector.
// A pattern of 1..MAX_LEN bits (bit [len-1] first, bit [0] last) is matched
// against the accepted bits of a gated serial stream, in overlapping or
// non-overlapping mode. Each match gives a registered one-cycle dout pulse and
// bumps a saturating match counter.

module seq_detector_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] PATTERN_RST = MAX_LEN'(8'b0001_0010),
   parameter int                 LEN_RST     = 5,
   parameter bit                 OVERLAP_RST = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       din,
   input  logic                       cfg_load,
   input  logic [MAX_LEN-1:0]         cfg_pattern,
   input  logic [$clog2(MAX_LEN):0]   cfg_len,
   input  logic                       cfg_overlap,
   input  logic                       cnt_clr,
   output logic                       dout,
   output logic [CNT_W-1:0]           match_cnt,
   output logic                       armed,
   output logic                       cfg_err
);

   localparam int LW = $clog2(MAX_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [MAX_LEN-1:0]   pat;
   logic [LW-1:0]        len;
   logic                 ovl;
   logic [MAX_LEN-1:0]   hist, hist_n, hist_shift, mask;
   logic [LW-1:0]        fill, fill_n, fill_inc;
   logic                 len_ok, cfg_ok, pat_eq, hit;

   // A length is usable only when it lies within 1..MAX_LEN.
   assign len_ok     = (len != '0) && (int'(len) <= MAX_LEN);
   assign cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
   assign hist_shift = {hist[MAX_LEN-2:0], din};
   assign fill_inc   = fill + LW'(1);
   assign armed      = (state == RUN);

   // Build a mask of the low len bits and compare the post-shift history
   // against the pattern only inside that window.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      pat_eq = (((hist_shift ^ pat) & mask) == '0);
   end

   // Next-state logic: config load overrides everything, then per-state
   // handling of accepted bits, then the non-overlap restart after a match.
   always_comb begin
      state_n = state;
      hist_n  = hist;
      fill_n  = fill;
      hit     = 1'b0;
      if (cfg_load) begin
         hist_n  = '0;
         fill_n  = '0;
         state_n = cfg_ok ? FILL : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (len_ok) begin
                  state_n = FILL;
               end
            end
            FILL: begin
               if (en) begin
                  hist_n = hist_shift;
                  fill_n = fill_inc;
                  if (fill_inc == len) begin
                     state_n = RUN;
                     hit     = pat_eq;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  hist_n = hist_shift;
                  hit    = pat_eq;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
         if (hit && !ovl) begin
            hist_n  = '0;
            fill_n  = '0;
            state_n = FILL;
         end
      end
   end

   // State, history and fill counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hist  <= '0;
         fill  <= '0;
      end else begin
         state <= state_n;
         hist  <= hist_n;
         fill  <= fill_n;
      end
   end

   // Configuration registers; an invalid length is still latched so the
   // block parks in IDLE until a valid load arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat     <= PATTERN_RST;
         len     <= LW'(LEN_RST);
         ovl     <= OVERLAP_RST;
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         pat     <= cfg_pattern;
         len     <= cfg_len;
         ovl     <= cfg_overlap;
         cfg_err <= !cfg_ok;
      end
   end

   // Registered match pulse and saturating match counter; clear beats a
   // simultaneous match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout      <= 1'b0;
         match_cnt <= '0;
      end else begin
         dout <= hit;
         if (cnt_clr) begin
            match_cnt <= '0;
         end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a queue-based behavioural model.

module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0;
   logic                 din = 1'b0;
   logic                 cfg_load = 1'b0;
   logic [MAX_LEN-1:0]   cfg_pattern = '0;
   logic [3:0]           cfg_len = '0;
   logic                 cfg_overlap = 1'b0;
   logic                 cnt_clr = 1'b0;
   logic                 dout;
   logic [CNT_W-1:0]     match_cnt;
   logic                 armed;
   logic                 cfg_err;

   typedef struct {
      logic dout;
      int   cnt;
      logic armed;
      logic err;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: accepted bits since the last clear, plus config.
   bit             mq[$];
   logic [7:0]     mpat;
   int             mlen;
   bit             movl;
   bit             mactive;
   int             mcnt;
   bit             merr;

   seq_detector_param #(
      .MAX_LEN(MAX_LEN),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .din(din),
      .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr),
      .dout(dout),
      .match_cnt(match_cnt),
      .armed(armed),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Monitor: after each rising edge, pop the expected response and compare.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            total++;
            if (dout !== e.dout || int'(match_cnt) != e.cnt || armed !== e.armed || cfg_err !== e.err) begin
               bad++;
               $display("[TB] FAIL scoreboard t=%0t got dout=%0b cnt=%0d armed=%0b err=%0b want dout=%0b cnt=%0d armed=%0b err=%0b",
                        $time, dout, match_cnt, armed, cfg_err, e.dout, e.cnt, e.armed, e.err);
            end
         end
      end
   end

   function automatic void modelReset();
      mq.delete();
      mpat    = 8'b0001_0010;
      mlen    = 5;
      movl    = 1'b1;
      mactive = 1'b0;
      mcnt    = 0;
      merr    = 1'b0;
   endfunction

   // Drive one clock worth of inputs, advance the model, push the expectation.
   task automatic applyStimulus(input bit e, input bit d, input bit ld = 1'b0,
                                input logic [7:0] lp = 8'h00, input int ll = 0,
                                input bit lo = 1'b0, input bit clr = 1'b0);
      bit   hit;
      exp_t x;
      en          = e;
      din         = d;
      cfg_load    = ld;
      cfg_pattern = lp;
      cfg_len     = 4'(ll);
      cfg_overlap = lo;
      cnt_clr     = clr;
      hit = 1'b0;
      if (ld) begin
         mpat    = lp;
         mlen    = ll;
         movl    = lo;
         mq.delete();
         mactive = (ll >= 1 && ll <= MAX_LEN);
         merr    = !mactive;
      end else if (!mactive) begin
         if (mlen >= 1 && mlen <= MAX_LEN) mactive = 1'b1;
      end else if (e) begin
         mq.push_back(d);
         if (mq.size() > MAX_LEN) void'(mq.pop_front());
         if (mq.size() >= mlen) begin
            hit = 1'b1;
            for (int i = 0; i < mlen; i++) begin
               if (mq[mq.size() - 1 - i] != mpat[i]) hit = 1'b0;
            end
            if (hit && !movl) mq.delete();
         end
      end
      if (clr) mcnt = 0;
      else if (hit && mcnt < CNT_MAX) mcnt++;
      x.dout  = hit;
      x.cnt   = mcnt;
      x.armed = mactive && (mq.size() >= mlen);
      x.err   = merr;
      expQ.push_back(x);
      @(negedge clk);
      en       = 1'b0;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic d, input int c,
                              input logic a, input logic e);
      total++;
      if (dout !== d || int'(match_cnt) != c || armed !== a || cfg_err !== e) begin
         bad++;
         $display("[TB] FAIL %s got dout=%0b cnt=%0d armed=%0b err=%0b want dout=%0b cnt=%0d armed=%0b err=%0b",
                  name, dout, match_cnt, armed, cfg_err, d, c, a, e);
      end
   endtask

   task automatic streamBits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i]);
   endtask

   initial begin
      logic [7:0] lp;
      int         ll;
      int         r;
      modelReset();
      #2;
      checkOutput("reset_hold", 1'b0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Defaults, overlap: one IDLE edge, then 1,0,0,1,0,0,1,0.
      applyStimulus(1'b1, 1'b1);
      streamBits(8'b1001_0010, 8);

      // Non-overlap with an explicit 10010 load.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'b0001_0010, 5, 1'b0);
      streamBits(8'b1001_0010, 8);

      // Gating: en=0 gaps between accepted bits.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'b0001_0010, 5, 1'b0);
      for (int i = 4; i >= 0; i--) begin
         applyStimulus(1'b1, (5'b10010 >> i) & 1'b1);
         applyStimulus(1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0);
      end

      // Invalid length parks the block; then a valid 3-bit pattern.
      applyStimulus(1'b1, 1'b1, 1'b1, 8'b0000_0001, 0, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i[0]);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'b0000_0101, 3, 1'b1);
      streamBits(8'b0001_0101, 5);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'b0000_0001, 9, 1'b1);
      applyStimulus(1'b1, 1'b1);

      // Counter saturation and clear-beats-match with a 1-bit pattern.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'b0000_0001, 1, 1'b1, 1'b1);
      repeat (5) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);

      // Async reset during a dout pulse, then a full fresh match is needed.
      applyStimulus(1'b0, 1'b0, 1'b1, 8'b0001_0010, 5, 1'b1);
      streamBits(8'b0001_0010, 5);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      applyStimulus(1'b1, 1'b1);
      streamBits(8'b0000_1001, 4);
      applyStimulus(1'b1, 1'b0);

      // Randomized traffic, biased toward short patterns to produce matches.
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            lp = 8'($urandom);
            ll = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(1, 4);
            applyStimulus(1'($urandom), 1'($urandom), 1'b1, lp, ll, 1'($urandom), r == 0);
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, r >= 97);
         end
      end

      @(posedge clk);
      #3;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain got pending=%0d want 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
